mux_lane_scheduler: RTL and testbench

//  4-lane byte scheduler for the phy_tx mux tree, all on clk_2f.

---
 rtl/mux_lane_scheduler.sv | 156 +++++++++++++++
 tb/tb_mux_lane_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_lane_scheduler.sv
// Four-lane byte scheduler: each lane is buffered in a small FIFO and one lane per cycle
// drives the output stream, either by fixed time slot or by skip-empty round-robin.
module mux_lane_scheduler #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic              valid_in2,
    input  logic              valid_in3,
    input  logic              mode,
    input  logic              pause,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        lane_out,
    output logic [3:0]        full,
    output logic [3:0]        empty,
    output logic [3:0]        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [4][DEPTH];
    logic [AW-1:0]     r_wrPtr [4];
    logic [AW-1:0]     r_rdPtr [4];
    logic [CW-1:0]     r_count [4];
    logic [3:0]        r_full;
    logic [3:0]        r_empty;
    logic [3:0]        r_overflow;
    logic [DATA_W-1:0] r_dataOut;
    logic              r_validOut;
    logic [1:0]        r_laneOut;
    logic [1:0]        r_rr;

    logic [DATA_W-1:0] w_dataIn [4];
    logic [3:0]        w_validIn;
    logic [3:0]        w_push;
    logic [3:0]        w_pop;
    logic [CW-1:0]     w_countNext [4];
    logic [1:0]        w_grantLane;
    logic [1:0]        w_cand;
    logic              w_grantValid;
    logic [DATA_W-1:0] w_head;

    assign w_dataIn[0] = data_in0;
    assign w_dataIn[1] = data_in1;
    assign w_dataIn[2] = data_in2;
    assign w_dataIn[3] = data_in3;
    assign w_validIn   = {valid_in3, valid_in2, valid_in1, valid_in0};

    // The registered full flag gates pushes, so a full lane rejects even while it pops.
    assign w_push = w_validIn & ~r_full;

    // Mode 1 scans offsets 3..0 so the lowest offset from rr is the one left standing.
    always_comb begin
        w_grantLane  = r_rr;
        w_grantValid = 1'b0;
        w_cand       = r_rr;
        w_pop        = '0;
        if (!pause) begin
            if (!mode) begin
                w_grantValid = !r_empty[r_rr];
            end else begin
                for (int k = 3; k >= 0; k--) begin
                    w_cand = r_rr + 2'(k);
                    if (!r_empty[w_cand]) begin
                        w_grantLane  = w_cand;
                        w_grantValid = 1'b1;
                    end
                end
            end
            if (w_grantValid) begin
                w_pop[w_grantLane] = 1'b1;
            end
        end
    end

    assign w_head = r_mem[w_grantLane][r_rdPtr[w_grantLane]];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_countNext[n] = r_count[n];
            if (w_push[n] && !w_pop[n]) begin
                w_countNext[n] = r_count[n] + 1'b1;
            end else if (!w_push[n] && w_pop[n]) begin
                w_countNext[n] = r_count[n] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        for (int n = 0; n < 4; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wrPtr[n]] <= w_dataIn[n];
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            for (int n = 0; n < 4; n++) begin
                r_wrPtr[n] <= '0;
                r_rdPtr[n] <= '0;
                r_count[n] <= '0;
            end
            r_full     <= 4'h0;
            r_empty    <= 4'hF;
            r_overflow <= 4'h0;
            r_dataOut  <= '0;
            r_validOut <= 1'b0;
            r_laneOut  <= 2'd0;
            r_rr       <= 2'd0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_push[n]) begin
                    r_wrPtr[n] <= r_wrPtr[n] + 1'b1;
                end
                if (w_pop[n]) begin
                    r_rdPtr[n] <= r_rdPtr[n] + 1'b1;
                end
                if (w_validIn[n] && r_full[n]) begin
                    r_overflow[n] <= 1'b1;
                end
                r_count[n] <= w_countNext[n];
                r_full[n]  <= (w_countNext[n] == FULL_CNT);
                r_empty[n] <= (w_countNext[n] == '0);
            end
            r_validOut <= w_grantValid;
            // An empty fixed slot still advances the rotation; an idle round-robin holds.
            if (w_grantValid) begin
                r_dataOut <= w_head;
                r_laneOut <= w_grantLane;
                r_rr      <= w_grantLane + 2'd1;
            end else if (!pause && !mode) begin
                r_laneOut <= r_rr;
                r_rr      <= r_rr + 2'd1;
            end
        end
    end

    assign data_out  = r_dataOut;
    assign valid_out = r_validOut;
    assign lane_out  = r_laneOut;
    assign full      = r_full;
    assign empty     = r_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_mux_lane_scheduler.sv
// Bench for mux_lane_scheduler: directed vector table, hand sequences for overflow,
// full-with-pop and pause/mode switching, then random traffic against a queue model.
module tb_mux_lane_scheduler;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic       clk2f = 1'b0;
    logic       resetL;
    logic       modeIn;
    logic       pauseIn;
    logic [3:0] validIn;
    logic [7:0] dataIn [4];
    logic [7:0] dataOut;
    logic       validOut;
    logic [1:0] laneOut;
    logic [3:0] fullOut;
    logic [3:0] emptyOut;
    logic [3:0] ovfOut;

    int total = 0;
    int bad   = 0;

    always #5 clk2f = ~clk2f;

    mux_lane_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_2f    (clk2f),
        .reset_L   (resetL),
        .data_in0  (dataIn[0]),
        .data_in1  (dataIn[1]),
        .data_in2  (dataIn[2]),
        .data_in3  (dataIn[3]),
        .valid_in0 (validIn[0]),
        .valid_in1 (validIn[1]),
        .valid_in2 (validIn[2]),
        .valid_in3 (validIn[3]),
        .mode      (modeIn),
        .pause     (pauseIn),
        .data_out  (dataOut),
        .valid_out (validOut),
        .lane_out  (laneOut),
        .full      (fullOut),
        .empty     (emptyOut),
        .overflow  (ovfOut)
    );

    // Reference model: one queue per lane plus the round-robin pointer.
    logic [7:0] mq [4][$];
    int         mRr;
    logic [7:0] mData;
    logic       mValid;
    logic [1:0] mLane;
    logic [3:0] mOvf;

    function automatic void modelStep();
        bit wasEmpty [4];
        bit wasFull  [4];
        bit found;
        int g;
        if (!resetL) begin
            for (int n = 0; n < 4; n++) mq[n].delete();
            mRr = 0; mData = 8'h00; mValid = 1'b0; mLane = 2'd0; mOvf = 4'h0;
            return;
        end
        for (int n = 0; n < 4; n++) begin
            wasEmpty[n] = (mq[n].size() == 0);
            wasFull[n]  = (mq[n].size() == DEPTH);
        end
        found = 1'b0;
        g = 0;
        if (!pauseIn) begin
            if (!modeIn) begin
                g = mRr;
                found = !wasEmpty[g];
                mLane = 2'(g);
                mRr = (mRr + 1) % 4;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!found && !wasEmpty[(mRr + k) % 4]) begin
                        g = (mRr + k) % 4;
                        found = 1'b1;
                    end
                end
            end
            if (found) begin
                mData = mq[g].pop_front();
                mLane = 2'(g);
                mRr = (g + 1) % 4;
            end
        end
        mValid = found;
        for (int n = 0; n < 4; n++) begin
            if (validIn[n]) begin
                if (wasFull[n]) mOvf[n] = 1'b1;
                else mq[n].push_back(dataIn[n]);
            end
        end
    endfunction

    function automatic logic [3:0] modelFull();
        logic [3:0] f;
        for (int n = 0; n < 4; n++) f[n] = (mq[n].size() == DEPTH);
        return f;
    endfunction

    function automatic logic [3:0] modelEmpty();
        logic [3:0] e;
        for (int n = 0; n < 4; n++) e[n] = (mq[n].size() == 0);
        return e;
    endfunction

    task automatic applyStimulus(input logic rstL, input logic md, input logic ps,
                                 input logic [3:0] vld, input logic [31:0] data);
        resetL  = rstL;
        modeIn  = md;
        pauseIn = ps;
        validIn = vld;
        for (int n = 0; n < 4; n++) dataIn[n] = data[n*8 +: 8];
        modelStep();
        @(posedge clk2f);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic [7:0] expData,
                               input logic [1:0] expLane, input logic [3:0] expFull,
                               input logic [3:0] expEmpty, input logic [3:0] expOvf);
        checkField({tag, ".valid"}, 32'(validOut), 32'(expValid));
        checkField({tag, ".data"},  32'(dataOut),  32'(expData));
        checkField({tag, ".lane"},  32'(laneOut),  32'(expLane));
        checkField({tag, ".full"},  32'(fullOut),  32'(expFull));
        checkField({tag, ".empty"}, 32'(emptyOut), 32'(expEmpty));
        checkField({tag, ".ovf"},   32'(ovfOut),   32'(expOvf));
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, mValid, mData, mLane, modelFull(), modelEmpty(), mOvf);
    endtask

    typedef struct packed {
        logic        rstL;
        logic        mode;
        logic        pause;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        expValid;
        logic [7:0]  expData;
        logic [1:0]  expLane;
        logic [3:0]  expFull;
        logic [3:0]  expEmpty;
        logic [3:0]  expOvf;
    } vec_t;

    vec_t vecs [15];
    int   nextIdx [4];
    int   popCount;
    int   rate;

    initial begin
        // rstL mode pause valid data | valid data lane full empty ovf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h55555555, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF, 4'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h55555555, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF, 4'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h55555555, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF, 4'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h00000000, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF, 4'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h00000000, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF, 4'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h5, 32'h00A200A0, 1'b0, 8'h00, 2'd0, 4'h0, 4'hA, 4'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 8'hA0, 2'd0, 4'h0, 4'hB, 4'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 8'hA0, 2'd1, 4'h0, 4'hB, 4'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 8'hA2, 2'd2, 4'h0, 4'hF, 4'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 8'hA2, 2'd3, 4'h0, 4'hF, 4'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 4'hA, 32'h33001100, 1'b0, 8'hA2, 2'd3, 4'h0, 4'h5, 4'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 4'h0, 32'h00000000, 1'b1, 8'h11, 2'd1, 4'h0, 4'h7, 4'h0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'h0, 32'h00000000, 1'b1, 8'h33, 2'd3, 4'h0, 4'hF, 4'h0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 4'h0, 32'h00000000, 1'b0, 8'h33, 2'd3, 4'h0, 4'hF, 4'h0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b0, 8'h33, 2'd0, 4'h0, 4'hF, 4'h0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rstL, vecs[i].mode, vecs[i].pause, vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData, vecs[i].expLane,
                        vecs[i].expFull, vecs[i].expEmpty, vecs[i].expOvf);
        end

        // Overflow: five pushes into a four-deep lane while paused, then drain.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 4'h4, {8'h00, 8'(i), 16'h0000});
            checkModel($sformatf("t4.fill%0d", i));
            if (i == 4) checkField("t4.fullAt4", 32'(fullOut), 32'h4);
        end
        checkField("t4.ovfSet", 32'(ovfOut), 32'h4);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
            checkModel($sformatf("t4.drain%0d", i));
            checkField($sformatf("t4.valid%0d", i), 32'(validOut), (i <= 4) ? 32'h1 : 32'h0);
            if (i <= 4) checkField($sformatf("t4.byte%0d", i), 32'(dataOut), 32'(i));
        end
        checkField("t4.ovfSticky", 32'(ovfOut), 32'h4);

        // Full lane pops while a new byte arrives: the byte is rejected.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        checkField("t5.ovfCleared", 32'(ovfOut), 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 4'h1, 32'(8'h10 + 8'(i)));
        checkField("t5.full", 32'(fullOut), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h1, 32'h000000EE);
        checkOutput("t5.pushPop", 1'b1, 8'h10, 2'd0, 4'h0, 4'hE, 4'h1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
            checkModel($sformatf("t5.drain%0d", i));
            checkField($sformatf("t5.valid%0d", i), 32'(validOut), (i <= 3) ? 32'h1 : 32'h0);
            if (i <= 3) checkField($sformatf("t5.byte%0d", i), 32'(dataOut), 32'(8'h10 + 8'(i)));
        end

        // Pause and mode switch mid-rotation with every lane loaded.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 32'h30201000);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 32'h31211101);
        for (int n = 0; n < 4; n++) nextIdx[n] = 0;
        popCount = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 2) applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
            else if (c < 4) applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
            else if (c < 5) applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
            else applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
            checkModel($sformatf("t6.c%0d", c));
            if (validOut === 1'b1) begin
                checkField($sformatf("t6.order%0d", c), 32'(dataOut),
                           32'(int'(laneOut) * 16 + nextIdx[laneOut]));
                nextIdx[laneOut]++;
                popCount++;
            end
        end
        checkField("t6.popCount", 32'(popCount), 32'd8);

        // Random traffic against the model, heavy load first, then light.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        modeIn = 1'b0;
        for (int c = 0; c < 800; c++) begin
            logic [3:0] vld;
            logic       md;
            rate = (c < 400) ? 35 : 12;
            for (int n = 0; n < 4; n++) vld[n] = ($urandom_range(0, 99) < rate);
            md = ($urandom_range(0, 19) == 0) ? ~modeIn : modeIn;
            applyStimulus($urandom_range(0, 149) != 0, md, $urandom_range(0, 4) == 0, vld, $urandom);
            checkModel($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
